acc_result_drain: RTL



---
 rtl/acc_result_drain.sv | 119 +++++++++++
 1 files changed

// File: rtl/acc_result_drain.sv
// acc_result_drain: captures LANES x LANE_W accumulator words into a DEPTH-entry
// register FIFO and drains them one lane per beat on an OUT_W valid/ready stream.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   in_valid, in_ready, in_data      accumulator word input (lane i = bits [i*LANE_W +: LANE_W])
//   out_valid, out_ready, out_data   lane beat output (sign-extended, or ReLU'd)
//   out_lane, out_last               index of current lane, high on lane LANES-1
//   level                            occupied FIFO entries
//   overflow                         sticky: word offered while full
//
// Build option: define ACC_RESULT_DRAIN_RELU_EN to clamp negative lanes to 0
// (non-negative lanes zero-extended). Default build sign-extends every lane.

module acc_result_drain #(
    parameter int LANES  = 16,
    parameter int LANE_W = 20,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*LANE_W-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(LANES)-1:0]   out_lane,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int LANE_IW = $clog2(LANES);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int WORD_W  = LANES * LANE_W;

    localparam logic [LANE_IW-1:0] LAST_LANE = LANE_IW'(LANES - 1);
    localparam logic [LVL_W-1:0]   FULL_LVL  = LVL_W'(DEPTH);

    logic [WORD_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [LVL_W-1:0]   r_level;
    logic [LANE_IW-1:0] r_lane;
    logic               r_overflow;

    logic               w_push;
    logic               w_beat;
    logic               w_last;
    logic               w_pop;
    logic [WORD_W-1:0]  w_head;
    logic [LANE_W-1:0]  w_lane_val;
    logic [OUT_W-1:0]   w_ext;

    // Handshake qualifiers depend only on registered level, so in_ready and
    // out_valid carry no combinational path from in_valid / out_ready.
    assign in_ready  = (r_level != FULL_LVL);
    assign out_valid = (r_level != '0);

    assign w_push = in_valid && in_ready;
    assign w_beat = out_valid && out_ready;
    assign w_last = (r_lane == LAST_LANE);
    assign w_pop  = w_beat && w_last;

    // Storage carries no reset: emptiness is tracked by r_level alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_lane     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_beat) begin
                r_lane <= w_last ? '0 : r_lane + LANE_IW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign w_lane_val = w_head[r_lane*LANE_W +: LANE_W];

`ifdef ACC_RESULT_DRAIN_RELU_EN
    assign w_ext = w_lane_val[LANE_W-1] ? '0 : OUT_W'(w_lane_val);
`else
    assign w_ext = OUT_W'($signed(w_lane_val));
`endif

    // Empty FIFO drives zeros rather than stale storage contents.
    assign out_data = out_valid ? w_ext : '0;
    assign out_lane = r_lane;
    assign out_last = out_valid && w_last;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule
